// File: rtl/pio_pkg.sv
// Shared constants for the PIO input-capture block: register map and edge selection.
package pio_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_edge_capture_if.sv
// Avalon-MM slave bus for the PIO input port, plus its level interrupt.
// Handshake: a write happens on any clock edge where chipselect=1 and write_n=0;
// readdata is reloaded every cycle from address and is valid one cycle later.
interface pio_in_edge_capture_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/pio_sync_edge.sv
// Multi-flop synchroniser for a WIDTH-bit asynchronous bus plus per-bit edge detection.
module pio_sync_edge
   import pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int EDGE_TYPE   = EDGE_RISE,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] edge_pulse
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  ahead;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // The edge is taken between the stage feeding the level and the level itself,
   // so a capture lands on the same edge as the level change (the level flop is
   // the "previous" value for the stage ahead of it).
   assign level = sync_q[SYNC_STAGES-1];
   assign ahead = sync_q[SYNC_STAGES-2];

   always_comb begin
      edge_pulse = '0;
      case (EDGE_TYPE)
         EDGE_RISE: edge_pulse = ahead & ~level;
         EDGE_FALL: edge_pulse = ~ahead & level;
         default:   edge_pulse = ahead ^ level;
      endcase
   end

endmodule

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO: synchronised level, maskable sticky edge capture, level irq.
module pio_in_edge_capture
   import pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int EDGE_TYPE   = EDGE_RISE,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [WIDTH-1:0]       in_port,
   pio_in_edge_capture_if.slave   bus
);

   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] edge_pulse;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] capture_next;
   logic [WIDTH-1:0] wdata;
   logic [31:0]      rd_mux;
   logic             wr_en;
   logic             unused_wdata;

   pio_sync_edge #(
      .WIDTH       (WIDTH),
      .EDGE_TYPE   (EDGE_TYPE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_port    (in_port),
      .level      (level),
      .edge_pulse (edge_pulse)
   );

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign wdata        = bus.writedata[WIDTH-1:0];
   assign unused_wdata = ^bus.writedata;

   // Clear first, then OR in new edges so a simultaneous set wins.
   always_comb begin
      capture_next = capture;
      if (wr_en && bus.address == ADDR_EDGE) begin
         capture_next = capture & ~wdata;
      end
      capture_next = capture_next | edge_pulse;
   end

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_DATA: rd_mux[WIDTH-1:0] = level;
         ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
         ADDR_EDGE: rd_mux[WIDTH-1:0] = capture;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask         <= '0;
         capture      <= '0;
         bus.readdata <= '0;
         bus.irq      <= 1'b0;
      end else begin
         if (wr_en && bus.address == ADDR_MASK) begin
            mask <= wdata;
         end
         capture      <= capture_next;
         bus.readdata <= rd_mux;
         bus.irq      <= |(capture & mask);
      end
   end

endmodule
